// File: rtl/fixed_point_slow_div.sv
// Iterative signed fixed-point divider: restoring long division, one quotient bit per clock.
// Define FIXED_POINT_SLOW_DIV_ROUND_EN to round half away from zero instead of truncating.
module fixed_point_slow_div #(
  parameter int NUM_WIDTH     = 16,
  parameter int NUM_FRAC_BITS = 14,
  parameter int DEN_WIDTH     = 16,
  parameter int DEN_FRAC_BITS = 14,
  parameter int Q_WIDTH       = 16,
  parameter int Q_FRAC_BITS   = 14
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic [NUM_WIDTH-1:0] num_in,
  input  logic [DEN_WIDTH-1:0] den_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic [Q_WIDTH-1:0]   q_out,
  output logic                 valid_out,
  output logic                 overflow_out,
  output logic                 div_zero_out
);

  // state | meaning
  // IDLE  | ready for operands
  // CALC  | ITER division steps, then result registration
  // DONE  | result valid for one cycle

  localparam int SHIFT = Q_FRAC_BITS + DEN_FRAC_BITS - NUM_FRAC_BITS;
  localparam int ITER  = NUM_WIDTH + SHIFT;
  localparam int CW    = $clog2(ITER + 1);

  localparam logic [CW-1:0]      LAST    = CW'(ITER);
  localparam logic [ITER:0]      ONE_M   = {{ITER{1'b0}}, 1'b1};
  localparam logic [ITER:0]      POS_LIM = (ONE_M << (Q_WIDTH - 1)) - ONE_M;
  localparam logic [ITER:0]      NEG_LIM = ONE_M << (Q_WIDTH - 1);
  localparam logic [Q_WIDTH-1:0] Q_MAX   = {1'b0, {(Q_WIDTH-1){1'b1}}};
  localparam logic [Q_WIDTH-1:0] Q_MIN   = {1'b1, {(Q_WIDTH-1){1'b0}}};

  generate
    if (SHIFT < 0) begin : g_bad_shift
      $error("fixed_point_slow_div: Q_FRAC_BITS + DEN_FRAC_BITS must be >= NUM_FRAC_BITS");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic                 neg_q, neg_d;
  logic                 num_neg_q, num_neg_d;
  logic                 num_zero_q, num_zero_d;
  logic [ITER-1:0]      dvd_q, dvd_d;
  logic [DEN_WIDTH-1:0] den_q, den_d;
  logic [DEN_WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [Q_WIDTH-1:0]   q_q, q_d;
  logic                 ovf_q, ovf_d;
  logic                 dz_q, dz_d;
  logic                 vld_q, vld_d;

  logic [NUM_WIDTH-1:0] num_abs;
  logic [DEN_WIDTH-1:0] den_abs;
  logic [DEN_WIDTH:0]   rem_sh;
  logic [DEN_WIDTH:0]   den_ext;
  logic                 ge;
  logic [DEN_WIDTH-1:0] rem_nx;
  logic [ITER-1:0]      dvd_nx;

  assign num_abs = num_in[NUM_WIDTH-1] ? (-num_in) : num_in;
  assign den_abs = den_in[DEN_WIDTH-1] ? (-den_in) : den_in;

  // The dividend register doubles as the quotient: each step consumes one
  // dividend bit at the top and appends one quotient bit at the bottom.
  assign rem_sh  = {rem_q, dvd_q[ITER-1]};
  assign den_ext = {1'b0, den_q};
  assign ge      = (rem_sh >= den_ext);
  assign rem_nx  = DEN_WIDTH'(ge ? (rem_sh - den_ext) : rem_sh);
  assign dvd_nx  = {dvd_q[ITER-2:0], ge};

  logic [ITER:0]      mag;
  logic [Q_WIDTH-1:0] q_res;
  logic               ovf_res;
  logic               dz_res;

  always_comb begin
    mag     = {1'b0, dvd_q};
    q_res   = '0;
    ovf_res = 1'b0;
    dz_res  = 1'b0;
`ifdef FIXED_POINT_SLOW_DIV_ROUND_EN
    if ({rem_q, 1'b0} >= {1'b0, den_q}) mag = mag + ONE_M;
`endif
    if (den_q == '0) begin
      dz_res = 1'b1;
      if (num_zero_q)     q_res = '0;
      else if (num_neg_q) q_res = Q_MIN;
      else                q_res = Q_MAX;
    end else if (neg_q && (mag != '0)) begin
      if (mag > NEG_LIM) begin
        q_res   = Q_MIN;
        ovf_res = 1'b1;
      end else begin
        q_res = Q_WIDTH'(-mag);
      end
    end else begin
      if (mag > POS_LIM) begin
        q_res   = Q_MAX;
        ovf_res = 1'b1;
      end else begin
        q_res = Q_WIDTH'(mag);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    neg_d      = neg_q;
    num_neg_d  = num_neg_q;
    num_zero_d = num_zero_q;
    dvd_d      = dvd_q;
    den_d      = den_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    q_d        = q_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    vld_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d    = CALC;
          neg_d      = num_in[NUM_WIDTH-1] ^ den_in[DEN_WIDTH-1];
          num_neg_d  = num_in[NUM_WIDTH-1];
          num_zero_d = (num_in == '0);
          dvd_d      = ITER'(num_abs) << SHIFT;
          den_d      = den_abs;
          rem_d      = '0;
          cnt_d      = '0;
        end
      end
      CALC: begin
        if (cnt_q != LAST) begin
          dvd_d = dvd_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = DONE;
          vld_d   = 1'b1;
          q_d     = q_res;
          ovf_d   = ovf_res;
          dz_d    = dz_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      neg_q      <= 1'b0;
      num_neg_q  <= 1'b0;
      num_zero_q <= 1'b0;
      dvd_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      q_q        <= '0;
      ovf_q      <= 1'b0;
      dz_q       <= 1'b0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      neg_q      <= neg_d;
      num_neg_q  <= num_neg_d;
      num_zero_q <= num_zero_d;
      dvd_q      <= dvd_d;
      den_q      <= den_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      dz_q       <= dz_d;
      vld_q      <= vld_d;
    end
  end

  assign ready_out    = (state_q == IDLE);
  assign q_out        = q_q;
  assign valid_out    = vld_q;
  assign overflow_out = ovf_q;
  assign div_zero_out = dz_q;

endmodule

// File: tb/tb_fixed_point_slow_div.sv
// Directed-vector bench for fixed_point_slow_div with hand-computed quotients.
module tb_fixed_point_slow_div;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [15:0] num_in;
  logic [15:0] den_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] q_out;
  logic        valid_out;
  logic        overflow_out;
  logic        div_zero_out;

  int n_total = 0;
  int n_bad   = 0;

`ifdef FIXED_POINT_SLOW_DIV_ROUND_EN
  localparam int EXP_2_3 = 10923;
`else
  localparam int EXP_2_3 = 10922;
`endif

  fixed_point_slow_div dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .num_in       (num_in),
    .den_in       (den_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .q_out        (q_out),
    .valid_out    (valid_out),
    .overflow_out (overflow_out),
    .div_zero_out (div_zero_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_vec(input string tag, input int num, input int den,
                         input int exp_q, input int exp_ovf, input int exp_dz);
    int lat;
    bit seen;
    bit rdy_bad;
    logic signed [15:0] qv;
    @(negedge clk_in);
    for (int i = 0; i < 100 && !ready_out; i++) @(negedge clk_in);
    num_in   = 16'(num);
    den_in   = 16'(den);
    valid_in = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    lat = 0; seen = 1'b0; rdy_bad = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk_in); #1;
      lat++;
      if (ready_out) rdy_bad = 1'b1;
      if (valid_out) seen = 1'b1;
    end
    qv = q_out;
    check_eq({tag, "_seen"}, int'(seen), 1);
    check_eq({tag, "_lat"}, lat, 31);
    check_eq({tag, "_rdy_busy"}, int'(rdy_bad), 0);
    check_eq({tag, "_q"}, int'(qv), exp_q);
    check_eq({tag, "_ovf"}, int'(overflow_out), exp_ovf);
    check_eq({tag, "_dz"}, int'(div_zero_out), exp_dz);
    @(posedge clk_in); #1;
    check_eq({tag, "_pulse"}, int'(valid_out), 0);
    check_eq({tag, "_rdy_after"}, int'(ready_out), 1);
  endtask

  int bb_num[4] = '{8192, -12288, 1, 4096};
  int bb_den[4] = '{16384, 16384, 3, -8192};
  int bb_q[4]   = '{8192, -12288, 5461, -8192};

  initial begin
    int exp_fifo[$];
    int n_acc;
    int n_vld;
    int stray;
    logic signed [15:0] qv;

    rst_n_in = 1'b0;
    valid_in = 1'b0;
    num_in   = '0;
    den_in   = '0;
    #12;
    check_eq("rst_ready", int'(ready_out), 1);
    check_eq("rst_valid", int'(valid_out), 0);
    check_eq("rst_q", int'(q_out), 0);
    check_eq("rst_ovf", int'(overflow_out), 0);
    check_eq("rst_dz", int'(div_zero_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    run_vec("neg075",   -12288, 16384, -12288, 0, 0);
    run_vec("mixsign",    4096, -8192,  -8192, 0, 0);
    run_vec("ovf_pos",   16384,  8192,  32767, 1, 0);
    run_vec("edge_neg", -16384,  8192, -32768, 0, 0);
    run_vec("two_3rd",       2,     3, EXP_2_3, 0, 0);
    run_vec("one_3rd",       1,     3,   5461, 0, 0);
    run_vec("dz_neg",     -100,     0, -32768, 0, 1);
    run_vec("dz_zero",       0,     0,      0, 0, 1);
    run_vec("after_dz",   8192, 16384,   8192, 0, 0);

    repeat (5) @(posedge clk_in);
    #1;
    qv = q_out;
    check_eq("hold_q", int'(qv), 8192);
    check_eq("hold_dz", int'(div_zero_out), 0);

    // valid_in held high with operands changing every cycle
    n_acc = 0;
    n_vld = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk_in);
      if (c < 132) begin
        num_in   = 16'(bb_num[c % 4]);
        den_in   = 16'(bb_den[c % 4]);
        valid_in = 1'b1;
        if (ready_out) begin
          exp_fifo.push_back(bb_q[c % 4]);
          n_acc++;
        end
      end else begin
        valid_in = 1'b0;
      end
      @(posedge clk_in); #1;
      if (valid_out) begin
        n_vld++;
        qv = q_out;
        check_eq("bb_rdy_done", int'(ready_out), 0);
        if (exp_fifo.size() > 0) check_eq("bb_q", int'(qv), exp_fifo.pop_front());
        else check_eq("bb_extra_valid", n_vld, n_acc);
      end
      if (c >= 132 && exp_fifo.size() == 0) break;
    end
    check_eq("bb_count", n_vld, n_acc);
    check_eq("bb_acc_min", int'(n_acc >= 3), 1);

    // reset asserted ten edges into CALC
    @(negedge clk_in);
    num_in   = 16'(-12288);
    den_in   = 16'(16384);
    valid_in = 1'b1;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1 rst_n_in = 1'b0;
    #1;
    check_eq("mid_rst_valid", int'(valid_out), 0);
    check_eq("mid_rst_ready", int'(ready_out), 1);
    check_eq("mid_rst_q", int'(q_out), 0);
    check_eq("mid_rst_ovf", int'(overflow_out), 0);
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    stray = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_in); #1;
      if (valid_out) stray++;
    end
    check_eq("mid_rst_stray", stray, 0);
    run_vec("post_rst", 8192, 16384, 8192, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
